gpu_cmd_sequencer: RTL
======================

# gpu_cmd_sequencer

Upstream feeder for the GPU's APB slave port. It accepts (address, data) register writes from the host-side command source over a valid/ready handshake and buffers them in a small FIFO. It replays them as well-formed APB write transfers into the GPU's pAddr/pDataWrite/pSel/pEnable/pWrite inputs. It stalls new transfers while the GPU reports its instruction FIFO full.

## Interface
Parameters:
- DEPTH, 8, command buffer entries; power of two, at least 2
- ADDR_W, 32, APB address width
- DATA_W, 32, APB write-data width

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- n_rst  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  host presents a command
- cmd_addr_i  in  ADDR_W  target register address
- cmd_data_i  in  DATA_W  write data
- cmd_ready_o  out  1  buffer can accept a command this cycle
- gpu_full_i  in  1  GPU instruction FIFO full (the GPU's fifo_full_o)
- pAddr_o  out  ADDR_W  APB address
- pDataWrite_o  out  DATA_W  APB write data
- pSel_o  out  1  APB select
- pEnable_o  out  1  APB enable
- pWrite_o  out  1  APB write strobe
- count_o  out  $clog2(DEPTH+1)  buffered entries
- idle_o  out  1  buffer empty and no transfer in progress

## Operation
- Push: occurs when cmd_valid_i and cmd_ready_o are both high at a rising edge. {addr, data} is written at the tail.
- cmd_ready_o = (count < DEPTH), decoded from the registered count only. It is never raised by a same-cycle pop.
- A push with cmd_ready_o low is ignored. The host must hold cmd_valid_i.
- APB FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when count > 0 and gpu_full_i == 0.
  - SETUP -> ACCESS unconditionally. The GPU slave has no pReady, so every transfer completes in one ACCESS cycle.
  - ACCESS -> SETUP when the post-pop count > 0 and gpu_full_i == 0. Otherwise ACCESS -> IDLE.
- Pop: the head entry is removed at the rising edge that ends ACCESS.
- The head entry is stable throughout SETUP and ACCESS.
- A push and a pop on the same edge leave count unchanged. Head and tail update independently.
- gpu_full_i is sampled only for the IDLE->SETUP and ACCESS->SETUP decisions. A transfer already in SETUP always completes.
- APB outputs, by state:
  - pSel_o = (SETUP or ACCESS).
  - pEnable_o = ACCESS.
  - pWrite_o = pSel_o.
  - pAddr_o and pDataWrite_o equal the head entry when pSel_o is high, and 0 in IDLE.
- idle_o = (state == IDLE) and (count == 0).
- Pointers are $clog2(DEPTH) bits and wrap naturally. count disambiguates full from empty.

## Timing
- Reset values: state IDLE, count 0, pointers 0, all APB outputs 0, cmd_ready_o 1, idle_o 1, count_o 0. Buffer contents are don't-care.
- Reset mid-transfer: APB outputs drop to 0 asynchronously and all buffered commands are discarded.
- Latency, with the command pushed at edge 0 into an empty buffer and gpu_full_i low:
  - count_o = 1 after edge 0.
  - SETUP from edge 1, ACCESS from edge 2.
  - Pop at edge 3, returning to IDLE.
- Sustained throughput: one write per 2 cycles (SETUP, ACCESS, SETUP, ...). No IDLE cycles are inserted while entries remain and gpu_full_i is low.
- Every output except cmd_ready_o, pAddr_o and pDataWrite_o is a pure function of registered state. Those three also depend only on registered count, pointers and buffer contents, with no combinational path from any input.

## Structure
- Package gpu_seq_pkg holds:
  - the state enum typedef (IDLE, SETUP, ACCESS);
  - the default DEPTH, ADDR_W and DATA_W constants.
- Sub-module gpu_cmd_buffer is a synchronous FIFO of {ADDR_W+DATA_W} entries. It provides push, pop, head data, count, full and empty.
- The top module holds the FSM and APB output decode.

## Test plan
- Reset then idle: after n_rst deasserts with no stimulus, all APB outputs stay 0 for 20 cycles and idle_o = 1, cmd_ready_o = 1.
- Single write: push {0x0000_0004, 0x1234_5678} at edge 0 -> pSel_o = 1 and pEnable_o = 0 after edge 1, pEnable_o = 1 after edge 2, address and data stable across both cycles, idle_o = 1 after edge 3.
- Back-to-back: push 4 commands on consecutive cycles -> APB issues exactly 4 SETUP/ACCESS pairs with no IDLE between them, in push order.
- Full buffer: push DEPTH = 8 commands with gpu_full_i = 1 -> count_o = 8, cmd_ready_o = 0, a 9th valid is not accepted, no pSel_o.
  - Then drop gpu_full_i -> all 8 drain in order and cmd_ready_o rises after the first pop.
- Stall mid-stream: raise gpu_full_i during the ACCESS of command 2 of 3 -> command 2 completes, FSM goes to IDLE, command 3 issues only after gpu_full_i falls.
- Async reset during ACCESS with 3 entries buffered -> pSel_o and pEnable_o go to 0 without waiting for an edge, count_o = 0, no further transfers after release.

Source files
------------

// File: rtl/gpu_seq_pkg.sv
// gpu_seq_pkg
// Shared types and default sizes for the GPU command sequencer.
//   seq_state_t : APB transfer FSM states (IDLE, SETUP, ACCESS)
//   DEF_*       : default buffer depth and APB address/data widths
package gpu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } seq_state_t;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/gpu_cmd_sequencer_if.sv
// gpu_cmd_sequencer_if
// Groups the host command handshake and the APB write bus of the sequencer.
//   cmd_valid_i/cmd_addr_i/cmd_data_i : host command (held until accepted)
//   cmd_ready_o                       : sequencer can take a command
//   gpu_full_i                        : GPU instruction FIFO full
//   pAddr_o/pDataWrite_o/pSel_o/pEnable_o/pWrite_o : APB write master
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high; the host holds valid and payload until then.
// modport slave is the sequencer side, modport master the host/GPU side.
interface gpu_cmd_sequencer_if
    import gpu_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cmd_valid_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic              cmd_ready_o;
    logic              gpu_full_i;
    logic [ADDR_W-1:0] pAddr_o;
    logic [DATA_W-1:0] pDataWrite_o;
    logic              pSel_o;
    logic              pEnable_o;
    logic              pWrite_o;

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_data_i, gpu_full_i,
        output cmd_ready_o, pAddr_o, pDataWrite_o, pSel_o, pEnable_o, pWrite_o
    );

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_data_i, gpu_full_i,
        input  cmd_ready_o, pAddr_o, pDataWrite_o, pSel_o, pEnable_o, pWrite_o
    );

endinterface

// File: rtl/gpu_cmd_buffer.sv
// gpu_cmd_buffer
// Synchronous FIFO holding {addr, data} commands.
//   clk, n_rst : clock, async active-low reset (pointers and count only)
//   push/push_data : write at tail (caller gates with !full)
//   pop            : remove head (ignored when empty)
//   head           : current head entry, read combinationally from storage
//   count/full/empty : occupancy, decoded from the registered count
module gpu_cmd_buffer
    import gpu_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = DEF_ADDR_W + DEF_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;

    // Storage carries no reset; stale contents are never visible because
    // count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are DEPTH-sized (power of two) and wrap on overflow.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// gpu_cmd_sequencer
// Buffers host register writes and replays them as APB write transfers to
// the GPU, holding off new transfers while the GPU FIFO reports full.
//   clk, n_rst : clock, async active-low reset
//   bus        : command handshake + APB master (gpu_cmd_sequencer_if.slave)
//   count_o    : buffered entries
//   idle_o     : buffer empty and FSM in IDLE
//   state_o    : current APB FSM state (debug visibility)
module gpu_cmd_sequencer
    import gpu_seq_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    gpu_cmd_sequencer_if.slave  bus,
    output logic [CNT_W-1:0]    count_o,
    output logic                idle_o,
    output seq_state_t          state_o
);

    seq_state_t                 state;
    seq_state_t                 state_next;
    logic                       push;
    logic                       pop;
    logic                       full;
    logic                       empty;
    logic                       more_after_pop;
    logic [CNT_W-1:0]           count;
    logic [ADDR_W+DATA_W-1:0]   head;

    // Ready comes only from the registered count, so a pop on the same edge
    // never opens the door early.
    assign push = bus.cmd_valid_i && !full;
    assign pop  = (state == ACCESS);

    gpu_cmd_buffer #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_buffer (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data ({bus.cmd_addr_i, bus.cmd_data_i}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Occupancy once the ACCESS pop (and any same-edge push) has landed.
    assign more_after_pop = (count > CNT_W'(1)) || push;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The GPU has no pReady, so SETUP always advances and ACCESS lasts one
    // cycle; gpu_full_i only gates the start of the next transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty && !bus.gpu_full_i) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (more_after_pop && !bus.gpu_full_i) begin
                    state_next = SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready_o  = !full;
    assign bus.pSel_o       = (state == SETUP) || (state == ACCESS);
    assign bus.pEnable_o    = (state == ACCESS);
    assign bus.pWrite_o     = bus.pSel_o;
    assign bus.pAddr_o      = bus.pSel_o ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign bus.pDataWrite_o = bus.pSel_o ? head[DATA_W-1:0] : '0;

    assign count_o = count;
    assign idle_o  = (state == IDLE) && empty;
    assign state_o = state;

endmodule
